// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
//
// Purpose: request/grant bus between the writeback sources and the
// register-file write arbiter. All requesters share one packed bus.
// Requester i uses bit i of the flag vectors, ReqAddr[i*D +: D] and
// ReqData[i*W +: W].
//
// Signals:
//   ReqValid  N    per-requester write request
//   ReqImm    N    request is an immediate load (targets register 2**D-1)
//   ReqAddr   N*D  packed destination addresses
//   ReqData   N*W  packed write data
//   ReqGrant  N    one-hot grant, combinational in the request cycle
//
// Modports:
//   master  requester side (drives requests, observes grant)
//   slave   arbiter side (observes requests, drives grant)
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int W = 8,
    parameter int D = 3,
    parameter int N = 3
);
    logic [N-1:0]   ReqValid;
    logic [N-1:0]   ReqImm;
    logic [N*D-1:0] ReqAddr;
    logic [N*W-1:0] ReqData;
    logic [N-1:0]   ReqGrant;

    modport master (
        output ReqValid,
        output ReqImm,
        output ReqAddr,
        output ReqData,
        input  ReqGrant
    );

    modport slave (
        input  ReqValid,
        input  ReqImm,
        input  ReqAddr,
        input  ReqData,
        output ReqGrant
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose: shares the single register-file write port among N writeback
// sources (ALU writeback, load unit, immediate loader, ...). One requester
// is granted per cycle, round-robin starting at the rotating pointer; the
// winning write is registered onto the register file's write inputs, so a
// grant in cycle t drives WriteEn in cycle t+1.
//
// Parameters:
//   W  data width (matches the register file)
//   D  register address width (2**D registers)
//   N  number of requesters (2..8)
//
// Ports:
//   Clk             in   clock, rising edge
//   Reset           in   asynchronous active-low reset (0 = reset)
//   req             if   request/grant bus (slave modport)
//   Hold            in   core stall; blocks all new grants
//   WriteEn         out  register-file write enable
//   Immediate       out  register-file immediate-load flag
//   Waddr           out  register-file write address
//   DataIn          out  register-file write data
//   ImmediateValue  out  register-file immediate value
//   Busy            out  registered: some ReqValid was high last cycle
//   WriteCount      out  saturating count of issued writes
//
// Optional feature (macro REGARB_HAZARD_EN):
//   RaddrA, RaddrB  in   read addresses to compare against the in-flight write
//   HazardA, HazardB out combinational read-after-write hazard flags
// With the macro undefined these ports and the hazard logic are absent.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int W = 8,
    parameter int D = 3,
    parameter int N = 3
) (
    input  logic                   Clk,
    input  logic                   Reset,
    regfile_write_arbiter_if.slave req,
    input  logic                   Hold,
    output logic                   WriteEn,
    output logic                   Immediate,
    output logic [D-1:0]           Waddr,
    output logic [W-1:0]           DataIn,
    output logic [W-1:0]           ImmediateValue,
    output logic                   Busy,
    output logic [15:0]            WriteCount
`ifdef REGARB_HAZARD_EN
    ,
    input  logic [D-1:0]           RaddrA,
    input  logic [D-1:0]           RaddrB,
    output logic                   HazardA,
    output logic                   HazardB
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [PW-1:0] ptr_wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [PW-1:0] rr_ptr;

    logic          grant_vld_p0;
    logic [PW-1:0] grant_idx_p0;
    logic          sel_imm_p0;
    logic [D-1:0]  sel_addr_p0;
    logic [W-1:0]  sel_data_p0;

    logic          vld_p1;
    logic          imm_p1;
    logic [D-1:0]  addr_p1;
    logic [W-1:0]  data_p1;
    logic [W-1:0]  ival_p1;
    logic          busy_p1;
    logic [15:0]   wcnt_p1;

    // ---- stage p0: combinational round-robin arbitration ------------------
    // The winner is the valid requester with the smallest forward distance
    // from rr_ptr (mod N), i.e. the first valid one in the order Ptr, Ptr+1...
    always_comb begin
        int best_d;
        int d;
        best_d       = N;
        d            = 0;
        grant_vld_p0 = 1'b0;
        grant_idx_p0 = '0;
        for (int i = 0; i < N; i++) begin
            d = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + N - int'(rr_ptr));
            if (req.ReqValid[i] && (d < best_d)) begin
                best_d       = d;
                grant_vld_p0 = 1'b1;
                grant_idx_p0 = PW'(i);
            end
        end
        // Reset and stall both suppress every grant.
        if (!Reset || Hold) begin
            grant_vld_p0 = 1'b0;
            grant_idx_p0 = '0;
        end
    end

    always_comb begin
        req.ReqGrant = '0;
        sel_imm_p0   = 1'b0;
        sel_addr_p0  = '0;
        sel_data_p0  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_vld_p0 && (grant_idx_p0 == PW'(i))) begin
                req.ReqGrant[i] = 1'b1;
                sel_imm_p0      = req.ReqImm[i];
                sel_addr_p0     = req.ReqAddr[i*D +: D];
                sel_data_p0     = req.ReqData[i*W +: W];
            end
        end
    end

    // ---- stage p1: registered register-file write port ---------------------
    // Payload registers hold their last value when no write is granted;
    // ImmediateValue only changes on immediate grants.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rr_ptr  <= '0;
            vld_p1  <= 1'b0;
            imm_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            ival_p1 <= '0;
            busy_p1 <= 1'b0;
            wcnt_p1 <= '0;
        end else begin
            vld_p1  <= grant_vld_p0;
            busy_p1 <= |req.ReqValid;
            if (grant_vld_p0) begin
                rr_ptr  <= ptr_wrap_inc(grant_idx_p0);
                imm_p1  <= sel_imm_p0;
                addr_p1 <= sel_imm_p0 ? {D{1'b1}} : sel_addr_p0;
                data_p1 <= sel_data_p0;
                if (sel_imm_p0) begin
                    ival_p1 <= sel_data_p0;
                end
                wcnt_p1 <= sat_inc(wcnt_p1);
            end
        end
    end

    assign WriteEn        = vld_p1;
    assign Immediate      = imm_p1;
    assign Waddr          = addr_p1;
    assign DataIn         = data_p1;
    assign ImmediateValue = ival_p1;
    assign Busy           = busy_p1;
    assign WriteCount     = wcnt_p1;

`ifdef REGARB_HAZARD_EN
    // An immediate write always lands in the top register regardless of Waddr.
    logic [D-1:0] eff_addr_p1;
    assign eff_addr_p1 = imm_p1 ? {D{1'b1}} : addr_p1;
    assign HazardA     = vld_p1 && (eff_addr_p1 == RaddrA);
    assign HazardB     = vld_p1 && (eff_addr_p1 == RaddrB);
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Scoreboard bench for regfile_write_arbiter. The driver issues requests at
// the falling edge, predicts the grant from a round-robin reference model and
// queues the expected register-file write; a separate monitor, sampling just
// after each rising edge, pops and compares whenever a write should appear.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int W = 8;
    localparam int D = 3;
    localparam int N = 3;

    typedef struct packed {
        logic         imm;
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic          Clk;
    logic          Reset;
    logic          Hold;
    logic          WriteEn;
    logic          Immediate;
    logic [D-1:0]  Waddr;
    logic [W-1:0]  DataIn;
    logic [W-1:0]  ImmediateValue;
    logic          Busy;
    logic [15:0]   WriteCount;
`ifdef REGARB_HAZARD_EN
    logic [D-1:0]  RaddrA;
    logic [D-1:0]  RaddrB;
    logic          HazardA;
    logic          HazardB;
    logic          fix_raddr;
`endif

    regfile_write_arbiter_if #(.W(W), .D(D), .N(N)) bus ();

    regfile_write_arbiter #(.W(W), .D(D), .N(N)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .req            (bus),
        .Hold           (Hold),
        .WriteEn        (WriteEn),
        .Immediate      (Immediate),
        .Waddr          (Waddr),
        .DataIn         (DataIn),
        .ImmediateValue (ImmediateValue),
        .Busy           (Busy),
        .WriteCount     (WriteCount)
`ifdef REGARB_HAZARD_EN
        ,
        .RaddrA         (RaddrA),
        .RaddrB         (RaddrB),
        .HazardA        (HazardA),
        .HazardB        (HazardB)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Requester state (owned by the driver)
    logic [N-1:0] vld;
    logic [N-1:0] imm;
    logic [D-1:0] addr [N];
    logic [W-1:0] data [N];
    int           last_g;

    // Reference model state
    int  m_ptr;
    int  m_cnt;
    logic exp_busy;
    wr_t exp_q [$];

    int n_checks;
    int n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Refill requesters that are idle or were just granted; pending ones
    // keep their payload stable until granted.
    task automatic refill(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!vld[i] || last_g == i) begin
                vld[i]  = (int'($urandom_range(99, 0)) < pct);
                imm[i]  = ($urandom_range(3, 0) == 0);
                addr[i] = D'($urandom);
                data[i] = W'($urandom);
            end
        end
    endtask

    task automatic step(input logic rst_v, input logic hold_v);
        int           g;
        logic [N-1:0] eg;
        wr_t          e;
        @(negedge Clk);
        Reset = rst_v;
        Hold  = hold_v;
        for (int i = 0; i < N; i++) begin
            bus.ReqValid[i]        = vld[i];
            bus.ReqImm[i]          = imm[i];
            bus.ReqAddr[i*D +: D]  = addr[i];
            bus.ReqData[i*W +: W]  = data[i];
        end
`ifdef REGARB_HAZARD_EN
        if (!fix_raddr) begin
            RaddrA = D'($urandom);
            RaddrB = D'($urandom);
        end
`endif
        #1;
        if (!rst_v) begin
            m_ptr = 0;
            m_cnt = 0;
            chk("rst_writeen", 32'(WriteEn), 32'd0);
            chk("rst_count", 32'(WriteCount), 32'd0);
        end
        // First valid requester scanning forward from the pointer.
        g = -1;
        if (rst_v && !hold_v) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        for (int i = 0; i < N; i++) eg[i] = (g == i);
        chk("grant", 32'(bus.ReqGrant), 32'(eg));
        if (g >= 0) begin
            e.imm  = imm[g];
            e.addr = imm[g] ? {D{1'b1}} : addr[g];
            e.data = data[g];
            exp_q.push_back(e);
            m_ptr = (g + 1) % N;
            if (m_cnt < 65535) m_cnt++;
        end
        exp_busy = rst_v && (vld != '0);
        last_g   = g;
    endtask

    // Monitor: checks the registered write port after every rising edge.
    initial begin
        wr_t          e;
        logic         l_imm;
        logic [D-1:0] l_addr;
        logic [W-1:0] l_data;
        logic [W-1:0] l_iv;
        logic         cur_we;
        logic [D-1:0] cur_eff;
        l_imm = 0; l_addr = '0; l_data = '0; l_iv = '0;
        forever begin
            @(posedge Clk);
            #2;
            cur_we  = 1'b0;
            cur_eff = '0;
            if (!Reset) begin
                l_imm = 0; l_addr = '0; l_data = '0; l_iv = '0;
                chk("rst_we_mon", 32'(WriteEn), 32'd0);
            end else begin
                chk("writeen", 32'(WriteEn), 32'(exp_q.size() > 0));
                if (exp_q.size() > 0) begin
                    e       = exp_q.pop_front();
                    l_imm   = e.imm;
                    l_addr  = e.addr;
                    l_data  = e.data;
                    if (e.imm) l_iv = e.data;
                    cur_we  = 1'b1;
                    cur_eff = e.addr;
                end
            end
            chk("immediate", 32'(Immediate), 32'(l_imm));
            chk("waddr", 32'(Waddr), 32'(l_addr));
            chk("datain", 32'(DataIn), 32'(l_data));
            chk("immvalue", 32'(ImmediateValue), 32'(l_iv));
            chk("busy", 32'(Busy), 32'(exp_busy));
            chk("writecount", 32'(WriteCount), 32'(m_cnt));
`ifdef REGARB_HAZARD_EN
            chk("hazardA", 32'(HazardA), 32'(cur_we && cur_eff == RaddrA));
            chk("hazardB", 32'(HazardB), 32'(cur_we && cur_eff == RaddrB));
`endif
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b0;
        Hold     = 1'b0;
        vld      = '0;
        imm      = '0;
        for (int i = 0; i < N; i++) begin
            addr[i] = '0;
            data[i] = '0;
        end
        bus.ReqValid = '0;
        bus.ReqImm   = '0;
        bus.ReqAddr  = '0;
        bus.ReqData  = '0;
        last_g   = -1;
        m_ptr    = 0;
        m_cnt    = 0;
        exp_busy = 1'b0;
`ifdef REGARB_HAZARD_EN
        fix_raddr = 1'b0;
        RaddrA    = '0;
        RaddrB    = '0;
`endif
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Single request from requester 0
        vld = 3'b001; imm = '0; addr[0] = 3'd3; data[0] = 8'h5A;
        step(1'b1, 1'b0);
        vld = '0;
        step(1'b1, 1'b0);
        chk("single_we", 32'(WriteEn), 32'd1);
        chk("single_waddr", 32'(Waddr), 32'd3);
        chk("single_data", 32'(DataIn), 32'h5A);
        chk("single_imm", 32'(Immediate), 32'd0);
        chk("single_count", 32'(WriteCount), 32'd1);

        // Reset during an in-flight write, then a fresh search from 0
        vld = 3'b010; addr[1] = 3'd2; data[1] = 8'h11;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        vld = 3'b111;
        step(1'b1, 1'b0);
        chk("post_rst_grant0", 32'(bus.ReqGrant), 32'd1);

        // Round-robin with all requesters continuously valid
        for (int c = 0; c < 6; c++) begin
            refill(100);
            step(1'b1, 1'b0);
        end

        // Immediate load from requester 2
        vld = 3'b100; imm = 3'b100; addr[2] = 3'd1; data[2] = 8'hC3;
        step(1'b1, 1'b0);
        vld = '0; imm = '0;
        step(1'b1, 1'b0);
        chk("imm_flag", 32'(Immediate), 32'd1);
        chk("imm_waddr", 32'(Waddr), 32'd7);
        chk("imm_value", 32'(ImmediateValue), 32'hC3);

        // Hold with pending requests, then release
        vld = 3'b011; addr[0] = 3'd4; data[0] = 8'h21; addr[1] = 3'd6; data[1] = 8'h42;
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1);
        chk("hold_busy", 32'(Busy), 32'd1);
        chk("hold_we", 32'(WriteEn), 32'd0);
        step(1'b1, 1'b0);
        refill(0);
        step(1'b1, 1'b0);
        refill(0);
        step(1'b1, 1'b0);

`ifdef REGARB_HAZARD_EN
        fix_raddr = 1'b1;
        RaddrA = 3'd5; RaddrB = 3'd4;
        vld = 3'b001; imm = '0; addr[0] = 3'd5; data[0] = 8'h77;
        step(1'b1, 1'b0);
        vld = '0;
        step(1'b1, 1'b0);
        chk("hz_a_hit", 32'(HazardA), 32'd1);
        chk("hz_b_miss", 32'(HazardB), 32'd0);
        RaddrB = 3'd7;
        vld = 3'b010; imm = 3'b010; addr[1] = 3'd0; data[1] = 8'h99;
        step(1'b1, 1'b0);
        vld = '0; imm = '0;
        step(1'b1, 1'b0);
        chk("hz_b_imm", 32'(HazardB), 32'd1);
        fix_raddr = 1'b0;
`endif

        // Randomized traffic with occasional stalls and resets
        last_g = -1;
        for (int c = 0; c < 3000; c++) begin
            refill(60);
            step(($urandom_range(99, 0) != 0), ($urandom_range(99, 0) < 15));
        end

        // Saturation: continuous grants past the counter limit
        for (int c = 0; c < 65540; c++) begin
            refill(100);
            step(1'b1, 1'b0);
        end
        vld = '0;
        step(1'b1, 1'b0);
        chk("sat_count", 32'(WriteCount), 32'hFFFF);

        @(posedge Clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
